// File: rtl/mod_cnt_pkg.sv
// mod_cnt_pkg: shared FSM encoding, default modulus and successor helper
//   state_t : HUNT / VERIFY / LOCKED tracker states
//   MOD_DEF : default counter modulus
//   nxt()   : expected successor of a counter value for modulus m
package mod_cnt_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int MOD_DEF = 5;

    function automatic logic [2:0] nxt(input logic [2:0] v, input int m);
        return (v == 3'(m - 1)) ? 3'd0 : v + 3'd1;
    endfunction

endpackage

// File: rtl/mod5_seq_checker_sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, q <= 0
//   clr   : clear; combined with inc the count restarts at 1
//   inc   : count one event, holding at all-ones
//   q     : current count
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= {{(W-1){1'b0}}, inc};
        else if (inc && q != '1)
            q <= q + 1'b1;
    end

endmodule

// File: rtl/mod5_seq_checker.sv
// mod5_seq_checker: verifies a modulo-MOD counter sequence, locks on a clean run
//   clk      : rising-edge clock shared with the observed counter
//   reset    : synchronous active-high reset
//   cnt_in   : observed counter value, sampled while chk_en=1
//   chk_en   : sample enable; all state holds when low
//   err_clr  : synchronous clear of err_cnt
//   locked   : tracker is in LOCKED
//   err      : one-cycle pulse per counted error
//   err_cnt  : saturating error count
//   wrap_cnt : verified MOD-1 -> 0 wraps while locked, modulo 2^CW
module mod5_seq_checker
    import mod_cnt_pkg::*;
#(
    parameter int MOD      = MOD_DEF,
    parameter int LOCK_RUN = 5,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    cnt_in,
    input  logic          chk_en,
    input  logic          err_clr,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] wrap_cnt
);

    state_t      r_state, w_state;
    logic [2:0]  r_exp, w_exp;
    logic [3:0]  r_run, w_run;
    logic        r_locked, r_err;
    logic [CW-1:0] r_wrap;
    logic        w_ill, w_match, w_err, w_wrap_inc;

    assign w_ill   = {1'b0, cnt_in} >= 4'(MOD);
    assign w_match = cnt_in == r_exp;

    // An illegal sample short-circuits the state case, so a sample that is
    // both illegal and mismatched raises exactly one error.
    always_comb begin
        w_state    = r_state;
        w_exp      = r_exp;
        w_run      = r_run;
        w_err      = 1'b0;
        w_wrap_inc = 1'b0;
        if (chk_en) begin
            if (w_ill) begin
                w_err   = 1'b1;
                w_state = HUNT;
                w_run   = 4'd0;
            end else begin
                case (r_state)
                    HUNT: begin
                        w_exp   = nxt(cnt_in, MOD);
                        w_run   = 4'd1;
                        w_state = VERIFY;
                    end
                    VERIFY: begin
                        if (w_match) begin
                            w_exp   = nxt(cnt_in, MOD);
                            w_run   = r_run + 4'd1;
                            w_state = (r_run + 4'd1 == 4'(LOCK_RUN)) ? LOCKED : VERIFY;
                        end else begin
                            w_state = HUNT;
                            w_run   = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            w_exp      = nxt(cnt_in, MOD);
                            w_wrap_inc = cnt_in == 3'd0;
                        end else begin
                            w_err   = 1'b1;
                            w_state = HUNT;
                            w_run   = 4'd0;
                        end
                    end
                    default: begin
                        w_state = HUNT;
                        w_run   = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= HUNT;
            r_exp    <= 3'd0;
            r_run    <= 4'd0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_wrap   <= '0;
        end else begin
            r_state  <= w_state;
            r_exp    <= w_exp;
            r_run    <= w_run;
            r_locked <= w_state == LOCKED;
            r_err    <= w_err;
            r_wrap   <= r_wrap + {{(CW-1){1'b0}}, w_wrap_inc};
        end
    end

    // Clear is gated by chk_en so that a disabled checker holds both counters.
    sat_cnt #(.W(CW)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (err_clr & chk_en),
        .inc   (w_err),
        .q     (err_cnt)
    );

    assign locked   = r_locked;
    assign err      = r_err;
    assign wrap_cnt = r_wrap;

endmodule

// File: tb/tb_mod5_seq_checker.sv
// tb_mod5_seq_checker: directed self-checking bench for mod5_seq_checker (MOD=5, LOCK_RUN=5, CW=8)
module tb_mod5_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] cnt_in = 3'd0;
    logic       chk_en = 1'b0;
    logic       err_clr = 1'b0;
    logic       locked, err;
    logic [7:0] err_cnt, wrap_cnt;

    int n_run = 0;
    int n_fail = 0;

    mod5_seq_checker dut (
        .clk      (clk),
        .reset    (reset),
        .cnt_in   (cnt_in),
        .chk_en   (chk_en),
        .err_clr  (err_clr),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic smp(input logic [2:0] v, input logic en = 1'b1, input logic clr = 1'b0, input logic rst = 1'b0);
        cnt_in  = v;
        chk_en  = en;
        err_clr = clr;
        reset   = rst;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic lock_seq();
        for (int i = 0; i < 5; i++) begin
            smp(3'(i));
            check("lock_err", err, 0);
            check("lock_state", locked, i == 4);
        end
    endtask

    initial begin
        smp(3'd0, 1'b0, 1'b0, 1'b1);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_wrap", wrap_cnt, 0);

        lock_seq();

        for (int i = 0; i < 6; i++) begin
            smp(3'(i % 5));
            check("wrap_err", err, 0);
            check("wrap_locked", locked, 1);
        end
        check("wrap_cnt_2", wrap_cnt, 2);
        check("wrap_err_cnt", err_cnt, 0);

        smp(3'd3);
        check("mis_err", err, 1);
        check("mis_err_cnt", err_cnt, 1);
        check("mis_locked", locked, 0);
        smp(3'd4);
        check("mis_err_once", err, 0);
        for (int i = 0; i < 4; i++) begin
            smp(3'(i));
            check("relock_state", locked, i == 3);
            check("relock_err", err, 0);
        end
        check("relock_wrap", wrap_cnt, 2);

        smp(3'd4, 1'b1, 1'b1);
        check("clr_locked", locked, 1);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_wrap", wrap_cnt, 2);

        for (int i = 0; i < 3; i++) begin
            smp(3'(5 + i % 3), 1'b0);
            check("hold_locked", locked, 1);
            check("hold_err", err, 0);
            check("hold_err_cnt", err_cnt, 0);
            check("hold_wrap", wrap_cnt, 2);
        end
        smp(3'd0);
        check("hold_resume_wrap", wrap_cnt, 3);
        check("hold_resume_locked", locked, 1);

        smp(3'd5);
        check("ill_lock_err", err, 1);
        check("ill_lock_once", err_cnt, 1);
        check("ill_lock_locked", locked, 0);

        smp(3'd0, 1'b0, 1'b0, 1'b1);
        smp(3'd6);
        check("hunt6_err", err, 1);
        check("hunt6_err_cnt", err_cnt, 1);
        check("hunt6_locked", locked, 0);
        lock_seq();

        smp(3'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) smp(3'd7);
        check("sat_err_cnt", err_cnt, 255);
        check("sat_err", err, 1);
        smp(3'd7, 1'b1, 1'b1);
        check("clr_err_same", err_cnt, 1);
        check("clr_err_pulse", err, 1);
        smp(3'd0, 1'b1, 1'b1);
        check("clr_alone", err_cnt, 0);
        check("clr_alone_err", err, 0);

        smp(3'd0, 1'b0, 1'b0, 1'b1);
        lock_seq();
        smp(3'd0);
        check("pre_rst_wrap", wrap_cnt, 1);
        smp(3'd1);
        smp(3'd6, 1'b1, 1'b1, 1'b1);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_wrap", wrap_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            smp(3'(7 - i), 1'b0);
            check("post_hold_locked", locked, 0);
            check("post_hold_err", err, 0);
            check("post_hold_err_cnt", err_cnt, 0);
            check("post_hold_wrap", wrap_cnt, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
